stage_mem_lsu: RTL and testbench
================================

Name: stage_mem_lsu

Overview:
Memory-stage load/store unit that consumes the execute stage's result bundle. The bundle is memory address, ALU op, store data, and writeback address/enable/data. The block drives a data-memory bus with a request/grant/response handshake and aligns load data. It stalls the pipeline while an access is outstanding and forwards a registered writeback bundle to the writeback stage.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, data bus width (fixed 32; byte enables are 4 bits)
TIMEOUT, 255, maximum cycles in WAIT before a bus error is flagged

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ex_valid  in  1  execute bundle valid this cycle
ex_aluop  in  AluOpBus  op code from the shared defines (EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP; any other op is a non-memory op)
mem_addr  in  ADDR_W  byte address from execute
rt_data  in  32  store data
reg_waddr_i  in  RegAddrBus  writeback register address
we_i  in  1  writeback enable
reg_wdata_i  in  32  non-memory result
stall_req  out  1  holds upstream stages
dmem_req  out  1  bus request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load word
wb_valid  out  1  writeback bundle valid
reg_waddr_o  out  RegAddrBus  writeback address
we_o  out  1  writeback enable
reg_wdata_o  out  32  writeback data
misalign  out  1  one-cycle pulse on a misaligned access
bus_err  out  1  one-cycle pulse on a response timeout

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Reset asserted mid-access aborts the access; dmem_req drops immediately and no writeback is produced.
- FSM states: IDLE, REQ, WAIT.
- Non-memory op with ex_valid in IDLE: reg_*_i is registered to the outputs with wb_valid=1 on the next cycle. Latency 1, no stall.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request is issued.
  - Next cycle: misalign=1, wb_valid=1, we_o=0.
  - The FSM stays in IDLE.
- Memory op accepted in IDLE:
  - The address, op, store data and waddr are captured.
  - The FSM goes to REQ.
  - stall_req is combinationally high in the acceptance cycle and in every REQ/WAIT cycle.
- REQ:
  - dmem_req=1 is held with stable dmem_addr/we/be/wdata until dmem_gnt=1.
  - Store with gnt: go to IDLE; next cycle wb_valid=1, we_o=0.
  - Load with gnt and rvalid in the same cycle: complete directly.
  - Load with gnt only: go to WAIT.
- WAIT:
  - dmem_req=0.
  - On rvalid: go to IDLE; next cycle wb_valid=1, we_o=we_i captured, reg_wdata_o = aligned load data.
  - A 9-bit counter increments each WAIT cycle. When it reaches TIMEOUT: go to IDLE, bus_err pulse, wb_valid=1, we_o=0.
- Store byte enables and data lanes:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 << addr[1:0]; wdata = halfword replicated ×2.
  - SW: be = 1111.
- Load alignment: select the byte/half at addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- wb_valid and the pulse outputs are high for exactly one cycle.
- The stall keeps the EX inputs stable, but the block uses only its captured copy after acceptance.
- dmem_gnt/dmem_rvalid arriving while in IDLE are ignored.
- stall_req deasserts in the cycle the FSM returns to IDLE. A new op may be accepted in that same cycle the registered completion is visible.

Test Plan:
- Non-memory op: ex_valid=1, EXE_ADD_OP, reg_wdata_i=0x1234, waddr=5, we_i=1 → next cycle wb_valid=1, reg_wdata_o=0x1234, reg_waddr_o=5, stall_req never high.
- LB: addr=0x1003, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x80FFFFFF → dmem_addr=0x1000, stall_req high for 6 cycles, reg_wdata_o=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH: addr=0x2002, rt_data=0x0000BEEF, gnt immediate → dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, wb_valid with we_o=0 two cycles after accept.
- LW: addr=0x3001 → no dmem_req, misalign=1 and wb_valid=1 with we_o=0 the next cycle.
- LW: addr=0x4000, gnt without rvalid, TIMEOUT=4 → bus_err pulse after 4 WAIT cycles, FSM back in IDLE, stall_req released.
- LW in WAIT, rst asserted → dmem_req, stall_req and wb_valid all 0 immediately. A late rvalid after reset release produces no writeback.

Source files
------------

// File: rtl/stage_mem_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
// The bus uses a request/grant handshake for commands and a separate rvalid response.
interface stage_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/stage_mem_lsu.sv
// Memory-stage load/store unit: issues data-memory accesses, aligns load data,
// stalls the pipeline while an access is outstanding, and registers the writeback bundle.
module stage_mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [7:0]        ex_aluop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        reg_waddr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  output logic              stall_req,
  stage_mem_lsu_if.master   dmem,
  output logic              wb_valid,
  output logic [4:0]        reg_waddr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [8:0] TO_LAST = 9'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [8:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [4:0]        waddr_q;
  logic              we_q;

  logic ex_is_mem, ex_mis, accept;
  logic q_is_store;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    ex_is_mem = 1'b0;
    ex_mis    = 1'b0;
    case (ex_aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: ex_is_mem = 1'b1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        ex_is_mem = 1'b1;
        ex_mis    = mem_addr[0];
      end
      EXE_LW_OP, EXE_SW_OP: begin
        ex_is_mem = 1'b1;
        ex_mis    = (mem_addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  assign accept    = (state == S_IDLE) && ex_valid && ex_is_mem && !ex_mis;
  // Reset gates the stall so a held memory op on the EX inputs cannot raise it.
  assign stall_req = !rst && (accept || (state != S_IDLE));

  always_comb begin
    q_is_store = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = wdata_q;
    case (op_q)
      EXE_SB_OP: begin
        q_is_store = 1'b1;
        be_c       = 4'b0001 << addr_q[1:0];
        wdata_c    = {4{wdata_q[7:0]}};
      end
      EXE_SH_OP: begin
        q_is_store = 1'b1;
        be_c       = 4'b0011 << addr_q[1:0];
        wdata_c    = {2{wdata_q[15:0]}};
      end
      EXE_SW_OP: q_is_store = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dmem.dmem_req   = (state == S_REQ);
    dmem.dmem_we    = dmem.dmem_req && q_is_store;
    dmem.dmem_addr  = dmem.dmem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    dmem.dmem_be    = dmem.dmem_req ? be_c : 4'b0000;
    dmem.dmem_wdata = dmem.dmem_req ? wdata_c : 32'h0;
  end

  always_comb begin
    lane_byte = 8'(dmem.dmem_rdata >> {addr_q[1:0], 3'b000});
    lane_half = addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (op_q)
      EXE_LB_OP:  load_data = {{24{lane_byte[7]}}, lane_byte};
      EXE_LBU_OP: load_data = {24'h0, lane_byte};
      EXE_LH_OP:  load_data = {{16{lane_half[15]}}, lane_half};
      EXE_LHU_OP: load_data = {16'h0, lane_half};
      default:    load_data = dmem.dmem_rdata;
    endcase
  end

  // Access FSM plus the registered writeback bundle; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wb_valid    <= 1'b0;
      reg_waddr_o <= '0;
      we_o        <= 1'b0;
      reg_wdata_o <= '0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid && !ex_is_mem) begin
            wb_valid    <= 1'b1;
            reg_waddr_o <= reg_waddr_i;
            we_o        <= we_i;
            reg_wdata_o <= reg_wdata_i;
          end else if (ex_valid && ex_mis) begin
            wb_valid    <= 1'b1;
            misalign    <= 1'b1;
            reg_waddr_o <= reg_waddr_i;
            we_o        <= 1'b0;
            reg_wdata_o <= '0;
          end else if (accept) begin
            addr_q  <= mem_addr;
            op_q    <= ex_aluop;
            wdata_q <= rt_data;
            waddr_q <= reg_waddr_i;
            we_q    <= we_i;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt) begin
            if (q_is_store) begin
              state       <= S_IDLE;
              wb_valid    <= 1'b1;
              reg_waddr_o <= waddr_q;
              we_o        <= 1'b0;
              reg_wdata_o <= '0;
            end else if (dmem.dmem_rvalid) begin
              state       <= S_IDLE;
              wb_valid    <= 1'b1;
              reg_waddr_o <= waddr_q;
              we_o        <= we_q;
              reg_wdata_o <= load_data;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid) begin
            state       <= S_IDLE;
            wb_valid    <= 1'b1;
            reg_waddr_o <= waddr_q;
            we_o        <= we_q;
            reg_wdata_o <= load_data;
          end else if (wait_cnt == TO_LAST) begin
            state       <= S_IDLE;
            bus_err     <= 1'b1;
            wb_valid    <= 1'b1;
            reg_waddr_o <= waddr_q;
            we_o        <= 1'b0;
            reg_wdata_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + 9'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Scoreboard bench for stage_mem_lsu: directed accesses push expected bus requests and
// writebacks into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_stage_mem_lsu;

  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef struct {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] data;
    logic        mis;
    logic        berr;
    bit          chk_data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_lanes;
  } req_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [7:0]  ex_aluop;
  logic [31:0] mem_addr;
  logic [31:0] rt_data;
  logic [4:0]  reg_waddr_i;
  logic        we_i;
  logic [31:0] reg_wdata_i;
  logic        stall_req;
  logic        wb_valid;
  logic [4:0]  reg_waddr_o;
  logic        we_o;
  logic [31:0] reg_wdata_o;
  logic        misalign;
  logic        bus_err;

  int check_cnt = 0;
  int pass_cnt  = 0;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  stage_mem_lsu_if #(.ADDR_W(32)) dmem_bus ();

  stage_mem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_aluop    (ex_aluop),
    .mem_addr    (mem_addr),
    .rt_data     (rt_data),
    .reg_waddr_i (reg_waddr_i),
    .we_i        (we_i),
    .reg_wdata_i (reg_wdata_i),
    .stall_req   (stall_req),
    .dmem        (dmem_bus.master),
    .wb_valid    (wb_valid),
    .reg_waddr_o (reg_waddr_o),
    .we_o        (we_o),
    .reg_wdata_o (reg_wdata_o),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic pushWb(input logic [4:0] waddr, input logic we, input logic [31:0] data,
                        input logic mis, input logic berr, input bit chk_data);
    wb_exp_t e;
    e.waddr = waddr; e.we = we; e.data = data; e.mis = mis; e.berr = berr; e.chk_data = chk_data;
    wb_q.push_back(e);
  endtask

  task automatic pushReq(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input bit chk_lanes);
    req_exp_t e;
    e.addr = addr; e.we = we; e.be = be; e.wdata = wdata; e.chk_lanes = chk_lanes;
    req_q.push_back(e);
  endtask

  // Monitor: granted requests and writebacks are compared against the queue heads.
  always @(negedge clk) begin
    if (!rst && dmem_bus.dmem_req && dmem_bus.dmem_gnt) begin
      if (req_q.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_req actual addr=%h required none", dmem_bus.dmem_addr);
      end else begin
        req_exp_t r;
        r = req_q.pop_front();
        checkOutput("req_addr", dmem_bus.dmem_addr, r.addr);
        checkOutput("req_we", 32'(dmem_bus.dmem_we), 32'(r.we));
        if (r.chk_lanes) begin
          checkOutput("req_be", 32'(dmem_bus.dmem_be), 32'(r.be));
          checkOutput("req_wdata", dmem_bus.dmem_wdata, r.wdata);
        end
      end
    end
    if (!rst && wb_valid) begin
      if (wb_q.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_wb actual data=%h required none", reg_wdata_o);
      end else begin
        wb_exp_t w;
        w = wb_q.pop_front();
        checkOutput("wb_we", 32'(we_o), 32'(w.we));
        checkOutput("wb_misalign", 32'(misalign), 32'(w.mis));
        checkOutput("wb_bus_err", 32'(bus_err), 32'(w.berr));
        if (w.chk_data) begin
          checkOutput("wb_waddr", 32'(reg_waddr_o), 32'(w.waddr));
          checkOutput("wb_data", reg_wdata_o, w.data);
        end
      end
    end
    if (!rst && !wb_valid && (misalign || bus_err)) begin
      check_cnt++;
      $display("[TB] FAIL stray_pulse actual mis=%b err=%b required 0", misalign, bus_err);
    end
  end

  // Issues one EX bundle at cycle 0 and plays a gnt/rvalid schedule; EX inputs are
  // scrambled after acceptance so only the captured copy can produce correct results.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] rt, input logic [4:0] waddr,
                               input logic we, input logic [31:0] wdata,
                               input int gnt_at, input int rv_at, input logic [31:0] rdata,
                               input int cycles, output int stall_n, output int req_n,
                               output int wb_at);
    stall_n = 0;
    req_n   = 0;
    wb_at   = -1;
    for (int c = 0; c < cycles; c++) begin
      ex_valid    = (c == 0);
      ex_aluop    = op;
      mem_addr    = (c == 0) ? addr : ~addr;
      rt_data     = (c == 0) ? rt : ~rt;
      reg_waddr_i = (c == 0) ? waddr : ~waddr;
      we_i        = we;
      reg_wdata_i = wdata;
      dmem_bus.dmem_gnt    = (c == gnt_at);
      dmem_bus.dmem_rvalid = (c == rv_at);
      dmem_bus.dmem_rdata  = (c == rv_at) ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (stall_req) stall_n++;
      if (dmem_bus.dmem_req) req_n++;
      if (wb_valid && wb_at < 0) wb_at = c;
      @(posedge clk);
      #1;
    end
    ex_valid = 1'b0;
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    int st, rq, wa, late_wb;
    rst = 1'b1;
    ex_valid = 1'b0; ex_aluop = '0; mem_addr = '0; rt_data = '0;
    reg_waddr_i = '0; we_i = 1'b0; reg_wdata_i = '0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_stall", 32'(stall_req), 32'h0);
    checkOutput("rst_req", 32'(dmem_bus.dmem_req), 32'h0);
    checkOutput("rst_addr", dmem_bus.dmem_addr, 32'h0);
    checkOutput("rst_be", 32'(dmem_bus.dmem_be), 32'h0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("rst_wdata_o", reg_wdata_o, 32'h0);
    checkOutput("rst_pulses", {30'h0, misalign, bus_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    pushWb(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
    applyStimulus(EXE_ADD_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, -1, -1, 32'h0, 3, st, rq, wa);
    checkOutput("alu_stall", 32'(st), 32'd0);
    checkOutput("alu_latency", 32'(wa), 32'd1);

    pushReq(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
    pushWb(5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
    applyStimulus(EXE_LB_OP, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 2, 5, 32'h80FF_FFFF, 8, st, rq, wa);
    checkOutput("lb_stall", 32'(st), 32'd6);
    checkOutput("lb_wb_at", 32'(wa), 32'd6);

    pushReq(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
    pushWb(5'd8, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
    applyStimulus(EXE_LBU_OP, 32'h1003, 32'h0, 5'd8, 1'b1, 32'h0, 2, 5, 32'h80FF_FFFF, 8, st, rq, wa);
    checkOutput("lbu_stall", 32'(st), 32'd6);

    pushReq(32'h2000, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    pushWb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(EXE_SH_OP, 32'h2002, 32'h0000_BEEF, 5'd3, 1'b0, 32'h0, 1, -1, 32'h0, 4, st, rq, wa);
    checkOutput("sh_stall", 32'(st), 32'd2);
    checkOutput("sh_wb_at", 32'(wa), 32'd2);

    pushWb(5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(EXE_LW_OP, 32'h3001, 32'h0, 5'd4, 1'b1, 32'h0, -1, -1, 32'h0, 3, st, rq, wa);
    checkOutput("mis_req_cycles", 32'(rq), 32'd0);
    checkOutput("mis_stall", 32'(st), 32'd0);
    checkOutput("mis_wb_at", 32'(wa), 32'd1);

    pushReq(32'h4000, 1'b0, 4'h0, 32'h0, 1'b0);
    pushWb(5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(EXE_LW_OP, 32'h4000, 32'h0, 5'd6, 1'b1, 32'h0, 1, -1, 32'h0, 9, st, rq, wa);
    checkOutput("to_stall", 32'(st), 32'd6);
    checkOutput("to_wb_at", 32'(wa), 32'd6);

    pushReq(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
    pushWb(5'd9, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1);
    applyStimulus(EXE_LH_OP, 32'h1002, 32'h0, 5'd9, 1'b1, 32'h0, 1, 1, 32'h8001_1234, 4, st, rq, wa);
    checkOutput("lh_stall", 32'(st), 32'd2);

    pushReq(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
    pushWb(5'd10, 1'b1, 32'h0000_8765, 1'b0, 1'b0, 1'b1);
    applyStimulus(EXE_LHU_OP, 32'h1000, 32'h0, 5'd10, 1'b1, 32'h0, 1, 2, 32'h1234_8765, 5, st, rq, wa);
    checkOutput("lhu_wb_at", 32'(wa), 32'd3);

    pushReq(32'h6000, 1'b1, 4'b0010, 32'hABAB_ABAB, 1'b1);
    pushWb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(EXE_SB_OP, 32'h6001, 32'h1234_56AB, 5'd11, 1'b1, 32'h0, 3, -1, 32'h0, 6, st, rq, wa);
    checkOutput("sb_stall", 32'(st), 32'd4);
    checkOutput("sb_req_cycles", 32'(rq), 32'd3);

    pushReq(32'h7000, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1);
    pushWb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(EXE_SW_OP, 32'h7000, 32'hCAFE_F00D, 5'd12, 1'b1, 32'h0, 1, -1, 32'h0, 4, st, rq, wa);

    pushReq(32'h5000, 1'b0, 4'h0, 32'h0, 1'b0);
    pushWb(5'd13, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    applyStimulus(EXE_LW_OP, 32'h5000, 32'h0, 5'd13, 1'b1, 32'h0, 1, 1, 32'hDEAD_BEEF, 4, st, rq, wa);

    // Reset while a load sits in WAIT, then a late response that must be ignored.
    pushReq(32'h8000, 1'b0, 4'h0, 32'h0, 1'b0);
    ex_valid = 1'b1; ex_aluop = EXE_LW_OP; mem_addr = 32'h8000; reg_waddr_i = 5'd14; we_i = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("wait_stall", 32'(stall_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_req", 32'(dmem_bus.dmem_req), 32'h0);
    checkOutput("rst_mid_stall", 32'(stall_req), 32'h0);
    checkOutput("rst_mid_wb", 32'(wb_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_gnt    = 1'b1;
    dmem_bus.dmem_rdata  = 32'h1111_2222;
    late_wb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid) late_wb++;
      @(posedge clk); #1;
      dmem_bus.dmem_rvalid = 1'b0;
      dmem_bus.dmem_gnt    = 1'b0;
    end
    checkOutput("late_rvalid_wb", 32'(late_wb), 32'd0);
    checkOutput("late_stall", 32'(stall_req), 32'h0);

    checkOutput("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    checkOutput("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
